vliw_bundle_loader: RTL and testbench

- Streams a compressed VLIW program image into instruction memory, one bundle at a time, replacing the per-bundle direct memory writes used today.
- Input is a word stream: a header word carrying the bundle address, then a slot-mask word, then only the non-NOP slot words.
- The block expands each bundle to a full NSLOT*SLOT_W word, zero-filling absent slots, and presents it on a write port with backpressure toward instruction memory.
- Slot count, slot width and address width are parameters, so the block serves the current 10-slot processor and wider derivatives.

---
 rtl/vliw_bundle_loader.sv | 145 ++++++++++++++
 tb/tb_vliw_bundle_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_bundle_loader.sv
// Expands a compressed VLIW program stream into full bundles for imem.
// Optional checksum word per bundle: define VLIW_LOADER_CSUM_EN.
module vliw_bundle_loader #(
  parameter int NSLOT  = 10,
  parameter int SLOT_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLOT_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [NSLOT*SLOT_W-1:0] out_data,
  output logic                    done,
  output logic                    err,
  output logic [CNT_W-1:0]        bundle_cnt
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_MASK = 3'd1;
  localparam logic [2:0] S_SLOT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
`ifdef VLIW_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'd4;
`endif

  logic [2:0]       state;
  logic [NSLOT-1:0] pend;
  logic [NSLOT-1:0] sel;
  logic [NSLOT-1:0] mask_w;
  logic             pend_last;
  logic             last_q;
  logic             acc;
`ifdef VLIW_LOADER_CSUM_EN
  logic [SLOT_W-1:0] csum;
`endif

  assign in_ready  = !rst && (state != S_EMIT);
  assign out_valid = (state == S_EMIT);
  assign acc       = in_valid && in_ready;
  assign mask_w    = in_data[NSLOT-1:0];
  // one-hot of the lowest still-pending slot
  assign sel       = pend & (~pend + NSLOT'(1));
  assign pend_last = ((pend & ~sel) == '0);
  assign done      = out_valid && out_ready && last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HDR;
      pend       <= '0;
      last_q     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      err        <= 1'b0;
      bundle_cnt <= '0;
`ifdef VLIW_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      unique case (state)
        S_HDR: if (acc) begin
          if (in_last) begin
            err <= 1'b1;
          end else begin
            out_addr <= in_data[ADDR_W-1:0];
            out_data <= '0;
            state    <= S_MASK;
`ifdef VLIW_LOADER_CSUM_EN
            csum     <= in_data;
`endif
          end
        end
        S_MASK: if (acc) begin
          pend <= mask_w;
`ifdef VLIW_LOADER_CSUM_EN
          csum <= csum ^ in_data;
          if (in_last) begin
            err   <= 1'b1;
            state <= S_HDR;
          end else if (mask_w == '0) begin
            state <= S_CSUM;
          end else begin
            state <= S_SLOT;
          end
`else
          if (mask_w == '0) begin
            last_q <= in_last;
            state  <= S_EMIT;
          end else if (in_last) begin
            err   <= 1'b1;
            state <= S_HDR;
          end else begin
            state <= S_SLOT;
          end
`endif
        end
        S_SLOT: if (acc) begin
          for (int i = 0; i < NSLOT; i++) begin
            if (sel[i]) out_data[(NSLOT-i)*SLOT_W-1 -: SLOT_W] <= in_data;
          end
          pend <= pend & ~sel;
`ifdef VLIW_LOADER_CSUM_EN
          csum <= csum ^ in_data;
          if (in_last) begin
            err   <= 1'b1;
            state <= S_HDR;
          end else if (pend_last) begin
            state <= S_CSUM;
          end
`else
          if (pend_last) begin
            last_q <= in_last;
            state  <= S_EMIT;
          end else if (in_last) begin
            err   <= 1'b1;
            state <= S_HDR;
          end
`endif
        end
`ifdef VLIW_LOADER_CSUM_EN
        S_CSUM: if (acc) begin
          if (in_data != csum) begin
            err   <= 1'b1;
            state <= S_HDR;
          end else begin
            last_q <= in_last;
            state  <= S_EMIT;
          end
        end
`endif
        S_EMIT: if (out_ready) begin
          bundle_cnt <= bundle_cnt + CNT_W'(1);
          state      <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_bundle_loader.sv
// Directed scoreboard bench for vliw_bundle_loader.
// Honours VLIW_LOADER_CSUM_EN by appending checksum words.
module tb_vliw_bundle_loader;

  localparam int NSLOT  = 10;
  localparam int SLOT_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int DW     = NSLOT * SLOT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SLOT_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic [DW-1:0]     out_data;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  bundle_cnt;

  vliw_bundle_loader #(
    .NSLOT(NSLOT), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .done(done), .err(err), .bundle_cnt(bundle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    logic              last;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  int          vecs = 0;
  int          fails = 0;
  logic [31:0] wbuf[NSLOT];

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vecs++;
        fails++;
        $error("FAIL unexpected_write: observed addr %0h expected none", out_addr);
      end else begin
        got = sb.pop_front();
        chk("sb_addr", DW'(out_addr), DW'(got.addr));
        chk("sb_data", out_data, got.data);
        chk("sb_done", DW'(done), DW'(got.last));
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    logic rdy;
    int   n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 100) begin
        vecs++;
        fails++;
        $error("FAIL in_ready_timeout: observed 0 expected 1");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic exp_t model(input logic [31:0] hdr,
                                 input logic [31:0] mask,
                                 input logic last);
    exp_t e;
    int   k;
    e.addr = hdr[ADDR_W-1:0];
    e.data = '0;
    e.last = last;
    k = 0;
    for (int i = 0; i < NSLOT; i++) begin
      if (mask[i]) begin
        e.data[(NSLOT-i)*SLOT_W-1 -: SLOT_W] = wbuf[k];
        k++;
      end
    end
    return e;
  endfunction

  function automatic int popc(input logic [31:0] mask);
    int k;
    k = 0;
    for (int i = 0; i < NSLOT; i++) if (mask[i]) k++;
    return k;
  endfunction

  task automatic send_tail(input logic [31:0] hdr, input logic [31:0] mask,
                           input logic last, input logic badcs);
    int          k;
    logic [31:0] cs;
    k  = popc(mask);
    cs = hdr ^ mask;
`ifdef VLIW_LOADER_CSUM_EN
    send_word(mask, 1'b0);
    for (int j = 0; j < k; j++) begin
      send_word(wbuf[j], 1'b0);
      cs = cs ^ wbuf[j];
    end
    send_word(badcs ? ~cs : cs, last);
`else
    send_word(mask, last && (k == 0));
    for (int j = 0; j < k; j++) send_word(wbuf[j], last && (j == k - 1));
    if (badcs) cs = '0;
`endif
  endtask

  task automatic send_bundle(input logic [31:0] hdr, input logic [31:0] mask,
                             input logic last, input logic badcs,
                             input logic expect_out);
    if (expect_out) sb.push_back(model(hdr, mask, last));
    send_word(hdr, 1'b0);
    send_tail(hdr, mask, last, badcs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_err", DW'(err), DW'(0));
    chk("rst_cnt", DW'(bundle_cnt), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset mid-bundle
    send_word(32'h8, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_in_ready", DW'(in_ready), DW'(0));
    chk("mid_rst_out_valid", DW'(out_valid), DW'(0));
    chk("mid_rst_addr", DW'(out_addr), DW'(0));
    chk("mid_rst_data", out_data, DW'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));
    repeat (3) @(posedge clk);
    #1;

`ifdef VLIW_LOADER_CSUM_EN
    wbuf[0] = 32'h11;
    send_bundle(32'h5, 32'h1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("csum_err", DW'(err), DW'(1));
    chk("csum_no_out", DW'(out_valid), DW'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    // empty bundle
    send_bundle(32'h32, 32'h000, 1'b1, 1'b0, 1'b1);
    chk("empty_valid", DW'(out_valid), DW'(1));
    chk("empty_done", DW'(done), DW'(1));
    @(posedge clk);
    #1;
    chk("empty_cnt", DW'(bundle_cnt), DW'(1));
    chk("empty_done_off", DW'(done), DW'(0));

    // sparse bundle, back-to-back words
    wbuf[0] = 32'h12345678;
    send_bundle(32'h1A, 32'h080, 1'b0, 1'b0, 1'b1);
    chk("sparse_latency", DW'(out_valid), DW'(1));
    chk("sparse_addr", DW'(out_addr), DW'(26));
    @(posedge clk);
    #1;
    chk("sparse_cnt", DW'(bundle_cnt), DW'(2));

    // backpressure
    out_ready = 1'b0;
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h0BADF00D;
    send_bundle(32'h77, 32'h201, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h78;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", DW'(out_valid), DW'(1));
      chk("bp_in_ready", DW'(in_ready), DW'(0));
      chk("bp_addr", DW'(out_addr), DW'(32'h77));
      chk("bp_data", out_data, {32'hDEADBEEF, 256'h0, 32'h0BADF00D});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hdr_ready", DW'(in_ready), DW'(1));
    wbuf[0] = 32'hCAFEF00D;
    sb.push_back(model(32'h78, 32'h002, 1'b0));
    @(posedge clk);
    #1;
    send_tail(32'h78, 32'h002, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_cnt", DW'(bundle_cnt), DW'(4));

    // in_last on a nonzero mask
    send_word(32'h40, 1'b0);
    send_word(32'h005, 1'b1);
    chk("perr_err", DW'(err), DW'(1));
    chk("perr_no_out", DW'(out_valid), DW'(0));
    wbuf[0] = 32'hA5A5A5A5;
    send_bundle(32'h2A, 32'h001, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("perr_sticky", DW'(err), DW'(1));

    // full bundle
    for (int i = 0; i < NSLOT; i++) wbuf[i] = 32'(i);
    send_bundle(32'h100, 32'h3FF, 1'b1, 1'b0, 1'b1);
    chk("full_data", out_data,
        {32'h0, 32'h1, 32'h2, 32'h3, 32'h4,
         32'h5, 32'h6, 32'h7, 32'h8, 32'h9});
    chk("full_done", DW'(done), DW'(1));
    @(posedge clk);
    #1;

    // mask bits above NSLOT ignored
    wbuf[0] = 32'h5555AAAA;
    send_bundle(32'h3, 32'hFFFFFC02, 1'b0, 1'b0, 1'b1);
    chk("hi_mask_data", out_data, {32'h0, 32'h5555AAAA, 256'h0});
    @(posedge clk);
    #1;

    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    #1;
    chk("sb_drained", DW'(sb.size()), DW'(0));
    chk("final_cnt", DW'(bundle_cnt), DW'(7));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
